// File: rtl/msg_request_scheduler_if.sv
// Grant handshake between the request scheduler (master) and the messenger (slave).
interface msg_request_scheduler_if #(
    parameter int unsigned PW = 64
);
    logic          GNT_VLD;
    logic [2:0]    GNT_SRC;
    logic [1:0]    GNT_THR;
    logic [PW-1:0] GNT_PARAM;
    logic          GNT_RDY;
    logic          DONE;

    modport master (
        output GNT_VLD, GNT_SRC, GNT_THR, GNT_PARAM,
        input  GNT_RDY, DONE
    );

    modport slave (
        input  GNT_VLD, GNT_SRC, GNT_THR, GNT_PARAM,
        output GNT_RDY, DONE
    );
endinterface

// File: rtl/msg_request_scheduler.sv
// Messenger front-end: latches EU/ERR/INT/NET requests and arbitrates them into
// one registered offer/accept grant that is held until the messenger reports DONE.
module msg_request_scheduler #(
    parameter int unsigned NTHR       = 4,
    parameter int unsigned PW         = 64,
    parameter logic [3:0]  STARVE_LIM = 4'd12
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    input  logic [NTHR-1:0]          EUREQ,
    input  logic [NTHR-1:0][PW-1:0]  EUPARAM,
    input  logic                     ERRREQ,
    input  logic                     INTREQ,
    input  logic                     NETREQ,
    msg_request_scheduler_if.master  gnt,
    output logic                     BUSY,
    output logic [NTHR-1:0]          EUOVF,
    output logic [NTHR+2:0]          PEND
);

    typedef enum logic [1:0] {IDLE, OFFER, SERVICE} state_t;
    typedef enum logic [2:0] {SRC_EU = 3'd0, SRC_ERR = 3'd1, SRC_INT = 3'd2, SRC_NET = 3'd3} src_t;

    state_t                   state;
    src_t                     gnt_src, arb_src;
    logic                     gnt_vld;
    logic [1:0]               gnt_thr;
    logic [PW-1:0]            gnt_param;
    logic [NTHR-1:0]          pend_eu;
    logic                     pend_err, pend_int, pend_net;
    logic [NTHR-1:0][PW-1:0]  param_buf;
    logic [1:0]               rr_ptr, rr_win, idx;
    logic [3:0]               starve;
    logic                     any_eu, any_pend, starved, rr_hit, accept;
    logic [NTHR-1:0]          clr_eu;
    logic                     clr_err, clr_int, clr_net;

    assign gnt.GNT_VLD   = gnt_vld;
    assign gnt.GNT_SRC   = gnt_src;
    assign gnt.GNT_THR   = gnt_thr;
    assign gnt.GNT_PARAM = gnt_param;
    assign BUSY          = (state != IDLE);
    assign PEND          = {pend_net, pend_int, pend_err, pend_eu};

    always_comb begin
        any_eu   = |pend_eu;
        any_pend = any_eu | pend_err | pend_int | pend_net;
        starved  = any_eu && (starve == STARVE_LIM);
        rr_hit   = 1'b0;
        rr_win   = rr_ptr;
        idx      = rr_ptr;
        for (int unsigned k = 0; k < NTHR; k++) begin
            idx = rr_ptr + 2'(k);
            if (!rr_hit && pend_eu[idx]) begin
                rr_hit = 1'b1;
                rr_win = idx;
            end
        end
        if (pend_err)      arb_src = SRC_ERR;
        else if (starved)  arb_src = SRC_EU;
        else if (pend_int) arb_src = SRC_INT;
        else if (pend_net) arb_src = SRC_NET;
        else               arb_src = SRC_EU;
    end

    always_comb begin
        accept  = (state == OFFER) && gnt.GNT_RDY;
        clr_eu  = (accept && gnt_src == SRC_EU) ? (NTHR'(1) << gnt_thr) : '0;
        clr_err = accept && (gnt_src == SRC_ERR);
        clr_int = accept && (gnt_src == SRC_INT);
        clr_net = accept && (gnt_src == SRC_NET);
    end

    // A pulse on the same edge that clears its flag wins: flag stays, buffer reloads.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pend_eu   <= '0;
            pend_err  <= 1'b0;
            pend_int  <= 1'b0;
            pend_net  <= 1'b0;
            param_buf <= '0;
            EUOVF     <= '0;
        end else begin
            pend_eu  <= (pend_eu & ~clr_eu) | EUREQ;
            EUOVF    <= EUREQ & pend_eu & ~clr_eu;
            pend_err <= (pend_err & ~clr_err) | ERRREQ;
            pend_int <= (pend_int & ~clr_int) | INTREQ;
            pend_net <= (pend_net & ~clr_net) | NETREQ;
            for (int unsigned i = 0; i < NTHR; i++) begin
                if (EUREQ[i] && (!pend_eu[i] || clr_eu[i]))
                    param_buf[i] <= EUPARAM[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            gnt_vld   <= 1'b0;
            gnt_src   <= SRC_EU;
            gnt_thr   <= '0;
            gnt_param <= '0;
            rr_ptr    <= '0;
            starve    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        gnt_vld <= 1'b1;
                        gnt_src <= arb_src;
                        state   <= OFFER;
                        if (arb_src == SRC_EU) begin
                            gnt_thr   <= rr_win;
                            gnt_param <= param_buf[rr_win];
                            rr_ptr    <= rr_win + 2'd1;
                            starve    <= '0;
                        end else begin
                            gnt_thr   <= '0;
                            gnt_param <= '0;
                            if (!any_eu)
                                starve <= '0;
                            else if (starve < STARVE_LIM)
                                starve <= starve + 4'd1;
                        end
                    end else begin
                        starve <= '0;
                    end
                end
                OFFER: begin
                    if (gnt.GNT_RDY) begin
                        gnt_vld <= 1'b0;
                        state   <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (gnt.DONE)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_request_scheduler.sv
// Bench for msg_request_scheduler: vector table plus hand sequences, grants checked via a queue.
module tb_msg_request_scheduler;
    localparam int unsigned PW = 64;

    logic               CLK = 1'b0;
    logic               RESETn = 1'b0;
    logic [3:0]         EUREQ = '0;
    logic [3:0][PW-1:0] EUPARAM = '0;
    logic               ERRREQ = 1'b0, INTREQ = 1'b0, NETREQ = 1'b0;
    logic               BUSY;
    logic [3:0]         EUOVF;
    logic [6:0]         PEND;

    msg_request_scheduler_if #(.PW(PW)) gnt ();

    msg_request_scheduler #(.NTHR(4), .PW(PW), .STARVE_LIM(4'd12)) dut (
        .CLK(CLK), .RESETn(RESETn), .EUREQ(EUREQ), .EUPARAM(EUPARAM),
        .ERRREQ(ERRREQ), .INTREQ(INTREQ), .NETREQ(NETREQ), .gnt(gnt),
        .BUSY(BUSY), .EUOVF(EUOVF), .PEND(PEND)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [2:0] src; logic [1:0] thr; logic [63:0] prm; } grant_t;
    typedef struct {
        logic err, intr, net; logic [3:0] eu; logic [63:0] prm;
        logic [2:0] xsrc; logic [1:0] xthr; logic [63:0] xprm;
    } vec_t;

    grant_t exp_q[$];
    vec_t   tbl[15];
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_grant(input logic [2:0] s, input logic [1:0] t, input logic [63:0] p);
        grant_t g;
        g.src = s; g.thr = t; g.prm = p;
        exp_q.push_back(g);
    endtask

    task automatic wait_offer(input string name);
        int unsigned n = 0;
        grant_t e;
        while (!gnt.GNT_VLD && n < 50) begin
            tick();
            n++;
        end
        if (!gnt.GNT_VLD) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: no offer within 50 cycles", name);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            return;
        end
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: unexpected offer src=%0d thr=%0d", name, gnt.GNT_SRC, gnt.GNT_THR);
            return;
        end
        e = exp_q.pop_front();
        chk({name, ".src"}, 64'(gnt.GNT_SRC), 64'(e.src));
        chk({name, ".thr"}, 64'(gnt.GNT_THR), 64'(e.thr));
        chk({name, ".param"}, gnt.GNT_PARAM, e.prm);
    endtask

    // Accepts the current offer (optionally pulsing requests on the accept edge), then DONE.
    task automatic serve(input string name, input logic [3:0] eu_acc, input logic [63:0] prm_acc,
                         input logic int_acc, input logic net_acc);
        wait_offer(name);
        gnt.GNT_RDY = 1'b1;
        EUREQ = eu_acc;
        for (int j = 0; j < 4; j++) EUPARAM[j] = prm_acc;
        INTREQ = int_acc;
        NETREQ = net_acc;
        tick();
        gnt.GNT_RDY = 1'b0; EUREQ = '0; INTREQ = 1'b0; NETREQ = 1'b0;
        gnt.DONE = 1'b1;
        tick();
        gnt.DONE = 1'b0;
    endtask

    initial begin
        logic [2:0]  h_src;
        logic [1:0]  h_thr;
        logic [63:0] h_prm;
        logic        changed;

        gnt.GNT_RDY = 1'b0;
        gnt.DONE    = 1'b0;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'hF, 64'h100, 3'd1, 2'd0, 64'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd2, 2'd0, 64'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd3, 2'd0, 64'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd0, 2'd0, 64'h0000_0000_0000_0100};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd0, 2'd1, 64'h0000_0001_0000_0100};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd0, 2'd2, 64'h0000_0002_0000_0100};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd0, 2'd3, 64'h0000_0003_0000_0100};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'h9, 64'h700, 3'd0, 2'd0, 64'h0000_0000_0000_0700};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd0, 2'd3, 64'h0000_0003_0000_0700};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4'h6, 64'h900, 3'd0, 2'd1, 64'h0000_0001_0000_0900};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd0, 2'd2, 64'h0000_0002_0000_0900};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 4'h0, 64'h0,   3'd2, 2'd0, 64'h0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd3, 2'd0, 64'h0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'h2, 64'hC00, 3'd3, 2'd0, 64'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 4'h0, 64'h0,   3'd0, 2'd1, 64'h0000_0001_0000_0C00};

        #1;
        chk("rst.vld",   64'(gnt.GNT_VLD),   64'd0);
        chk("rst.src",   64'(gnt.GNT_SRC),   64'd0);
        chk("rst.thr",   64'(gnt.GNT_THR),   64'd0);
        chk("rst.param", gnt.GNT_PARAM,      64'd0);
        chk("rst.busy",  64'(BUSY),          64'd0);
        chk("rst.euovf", 64'(EUOVF),         64'd0);
        chk("rst.pend",  64'(PEND),          64'd0);
        tick(); tick();
        RESETn = 1'b1;
        tick();

        for (int i = 0; i < 15; i++) begin
            ERRREQ = tbl[i].err; INTREQ = tbl[i].intr; NETREQ = tbl[i].net; EUREQ = tbl[i].eu;
            for (int j = 0; j < 4; j++) EUPARAM[j] = {32'(j), tbl[i].prm[31:0]};
            tick();
            ERRREQ = 1'b0; INTREQ = 1'b0; NETREQ = 1'b0; EUREQ = '0;
            if (i == 0) chk("all7.pend", 64'(PEND), 64'h7F);
            expect_grant(tbl[i].xsrc, tbl[i].xthr, tbl[i].xprm);
            serve($sformatf("vec%0d", i), 4'h0, 64'h0, 1'b0, 1'b0);
        end

        // Single EU request; RDY and DONE together in the offer cycle.
        for (int j = 0; j < 4; j++) EUPARAM[j] = {$urandom, $urandom};
        EUPARAM[2] = 64'hA5;
        EUREQ = 4'b0100;
        tick();
        EUREQ = '0;
        chk("A.pend", 64'(PEND), 64'b0000100);
        chk("A.vld_early", 64'(gnt.GNT_VLD), 64'd0);
        expect_grant(3'd0, 2'd2, 64'hA5);
        tick();
        chk("A.vld_k1", 64'(gnt.GNT_VLD), 64'd1);
        wait_offer("A");
        gnt.GNT_RDY = 1'b1; gnt.DONE = 1'b1;
        tick();
        gnt.GNT_RDY = 1'b0; gnt.DONE = 1'b0;
        chk("A.pend_clr", 64'(PEND), 64'd0);
        chk("A.vld_drop", 64'(gnt.GNT_VLD), 64'd0);
        chk("A.busy_svc", 64'(BUSY), 64'd1);
        tick(); tick();
        chk("A.busy_wait", 64'(BUSY), 64'd1);
        gnt.DONE = 1'b1;
        tick();
        gnt.DONE = 1'b0;
        chk("A.busy_idle", 64'(BUSY), 64'd0);

        // Repeat request while pending: overflow pulse, original parameter kept.
        EUPARAM[1] = 64'h1; EUREQ = 4'b0010;
        tick();
        chk("B.ovf_first", 64'(EUOVF), 64'd0);
        EUPARAM[1] = 64'h2;
        tick();
        EUREQ = '0;
        chk("B.ovf_pulse", 64'(EUOVF), 64'b0010);
        tick();
        chk("B.ovf_gone", 64'(EUOVF), 64'd0);
        expect_grant(3'd0, 2'd1, 64'h1);
        serve("B", 4'h0, 64'h0, 1'b0, 1'b0);
        chk("B.pend", 64'(PEND), 64'd0);

        // New request on the clearing edge wins and reloads the buffer.
        for (int j = 0; j < 4; j++) EUPARAM[j] = 64'h30;
        EUREQ = 4'b1000;
        tick();
        EUREQ = '0;
        expect_grant(3'd0, 2'd3, 64'h30);
        wait_offer("C1");
        gnt.GNT_RDY = 1'b1; EUREQ = 4'b1000;
        for (int j = 0; j < 4; j++) EUPARAM[j] = 64'h33;
        tick();
        gnt.GNT_RDY = 1'b0; EUREQ = '0;
        chk("C.pend_kept", 64'(PEND), 64'b0001000);
        chk("C.no_ovf", 64'(EUOVF), 64'd0);
        gnt.DONE = 1'b1;
        tick();
        gnt.DONE = 1'b0;
        expect_grant(3'd0, 2'd3, 64'h33);
        serve("C2", 4'h0, 64'h0, 1'b0, 1'b0);

        // Starvation: INT/NET re-pulsed every grant while EU thread 0 waits.
        for (int j = 0; j < 4; j++) EUPARAM[j] = 64'hD0;
        EUREQ = 4'b0001; INTREQ = 1'b1; NETREQ = 1'b1;
        tick();
        EUREQ = '0; INTREQ = 1'b0; NETREQ = 1'b0;
        for (int n = 0; n < 12; n++) begin
            expect_grant(3'd2, 2'd0, 64'h0);
            serve($sformatf("D.int%0d", n), 4'h0, 64'h0, 1'b1, 1'b1);
        end
        expect_grant(3'd0, 2'd0, 64'hD0);
        serve("D.eu", 4'b0001, 64'hD1, 1'b0, 1'b0);
        expect_grant(3'd2, 2'd0, 64'h0);
        serve("D.int_after", 4'h0, 64'h0, 1'b0, 1'b0);
        expect_grant(3'd3, 2'd0, 64'h0);
        serve("D.net_after", 4'h0, 64'h0, 1'b0, 1'b0);
        expect_grant(3'd0, 2'd0, 64'hD1);
        serve("D.eu2", 4'h0, 64'h0, 1'b0, 1'b0);

        // Long-held offer is not pre-empted by a later ERR.
        NETREQ = 1'b1;
        tick();
        NETREQ = 1'b0;
        expect_grant(3'd3, 2'd0, 64'h0);
        wait_offer("E1");
        h_src = gnt.GNT_SRC; h_thr = gnt.GNT_THR; h_prm = gnt.GNT_PARAM;
        changed = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ERRREQ = (c == 5);
            tick();
            ERRREQ = 1'b0;
            if (!gnt.GNT_VLD || gnt.GNT_SRC !== h_src || gnt.GNT_THR !== h_thr || gnt.GNT_PARAM !== h_prm)
                changed = 1'b1;
        end
        chk("E.hold", 64'(changed), 64'd0);
        gnt.GNT_RDY = 1'b1;
        tick();
        gnt.GNT_RDY = 1'b0; gnt.DONE = 1'b1;
        tick();
        gnt.DONE = 1'b0;
        chk("E.err_pend", 64'(PEND), 64'b0010000);
        expect_grant(3'd1, 2'd0, 64'h0);
        serve("E2", 4'h0, 64'h0, 1'b0, 1'b0);

        // Asynchronous reset during SERVICE.
        INTREQ = 1'b1; EUREQ = 4'b0100;
        tick();
        INTREQ = 1'b0; EUREQ = '0;
        expect_grant(3'd2, 2'd0, 64'h0);
        wait_offer("F");
        gnt.GNT_RDY = 1'b1;
        tick();
        gnt.GNT_RDY = 1'b0; NETREQ = 1'b1;
        tick();
        NETREQ = 1'b0;
        chk("F.busy_svc", 64'(BUSY), 64'd1);
        #2 RESETn = 1'b0;
        #1;
        chk("F.rst_vld",  64'(gnt.GNT_VLD), 64'd0);
        chk("F.rst_busy", 64'(BUSY), 64'd0);
        chk("F.rst_pend", 64'(PEND), 64'd0);
        tick();
        RESETn = 1'b1;
        changed = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (gnt.GNT_VLD || BUSY || PEND != 7'd0) changed = 1'b1;
        end
        chk("F.idle_after", 64'(changed), 64'd0);
        EUPARAM[0] = 64'hF0; EUPARAM[3] = 64'hF3; EUREQ = 4'b1001;
        tick();
        EUREQ = '0;
        expect_grant(3'd0, 2'd0, 64'hF0);
        serve("F.rr0", 4'h0, 64'h0, 1'b0, 1'b0);
        expect_grant(3'd0, 2'd3, 64'hF3);
        serve("F.rr3", 4'h0, 64'h0, 1'b0, 1'b0);
        chk("sb.empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/msg_request_scheduler.md
Name: msg_request_scheduler

Overview:
Front-end scheduler for the four-thread messenger microcontroller. It latches message requests from four EU threads plus the error, interrupt and network sources, and arbitrates them into a single registered offer/accept handshake. It holds each grant until the messenger signals completion, then arbitrates again. Parameters captured at request time stay stable for the whole service.

Parameters:
NTHR, 4, number of EU threads (fixed 4; thread index is 2 bits)
PW, 64, EU parameter width (message index [31:0], parameter [63:32])
STARVE_LIM, 4'd12, non-EU grants allowed while any EU request waits before EU is promoted

Ports:
CLK  in  1  clock, rising edge
RESETn  in  1  asynchronous active-low reset
EUREQ  in  4  per-thread single-cycle request pulse
EUPARAM  in  4xPW  per-thread parameter, sampled with EUREQ
ERRREQ  in  1  error request pulse
INTREQ  in  1  interrupt request pulse
NETREQ  in  1  network request pulse
GNT_VLD  out  1  offer valid
GNT_SRC  out  3  0=EU, 1=ERR, 2=INT, 3=NET
GNT_THR  out  2  EU thread of the offer (0 when not EU)
GNT_PARAM  out  PW  captured EU parameter (0 when not EU)
GNT_RDY  in  1  messenger accepts the offer
DONE  in  1  messenger finished servicing the accepted grant
BUSY  out  1  state != IDLE
EUOVF  out  4  one-cycle pulse: EUREQ arrived while that thread was already pending
PEND  out  7  {NET,INT,ERR,EU[3:0]} pending flags

Behaviour:
Reset values:
- all pending flags 0; GNT_VLD 0; GNT_SRC 0; GNT_THR 0; GNT_PARAM 0; BUSY 0; EUOVF 0.
- rr_ptr 0; starve counter 0; state IDLE.
- Reset mid-offer or mid-service drops everything immediately, with no completion.

Capture:
- EUREQ[i] with pend_eu[i]=0 sets pend_eu[i] and loads param_buf[i] at the same edge.
- EUREQ[i] with pend_eu[i]=1 leaves the buffer unchanged and pulses EUOVF[i] for 1 cycle.
- ERR/INT/NET pulses set sticky pend flags. A repeat while pending is silently merged.
- The same edge that clears a flag on grant may also see a new pulse for that source. The new pulse wins: the flag stays set and param_buf reloads.

FSM (IDLE, OFFER, SERVICE):
- IDLE: if any pend, arbitrate, register the GNT_* fields, set GNT_VLD and go to OFFER. Otherwise stay.
- OFFER: GNT_* are held stable. When GNT_RDY=1, clear the granted pend flag, drop GNT_VLD and go to SERVICE.
- SERVICE: wait for DONE=1, then go to IDLE. DONE is ignored in IDLE and OFFER.
- Latency: a pulse sampled at edge k sets pend at k. GNT_VLD is high after edge k+1. The minimum gap between consecutive offers is 2 cycles after DONE.

Arbitration (evaluated only in IDLE):
- Fixed priority is ERR > INT > NET > EU.
- Starvation override: if any pend_eu is set and starve = STARVE_LIM, EU beats INT and NET. ERR always wins.
- EU round-robin: search from rr_ptr upward, mod 4; the first pending thread wins. On an EU grant, rr_ptr becomes winner+1 (mod 4).

Starve counter (4-bit):
- On a non-EU grant while any pend_eu is set: increment, saturating at STARVE_LIM.
- On an EU grant, or when no EU is pending: clear to 0.

Offer fields for non-EU grants: GNT_THR=0 and GNT_PARAM=0.

Boundary cases:
- Simultaneous requests from all 7 sources are all latched; none is lost.
- Requests arriving during OFFER or SERVICE are latched and considered at the next IDLE.
- GNT_RDY and DONE asserted in the same cycle as the offer: DONE is not honoured until SERVICE.

Test Plan:
- EUREQ=4'b0100 with EUPARAM[2]=64'hA5 at cycle 0, GNT_RDY=1 -> GNT_VLD rises after edge 1 with SRC=0, THR=2, PARAM=64'hA5; PEND[2] clears after the accept; BUSY stays 1 until DONE.
- ERRREQ, INTREQ, NETREQ and EUREQ=4'hF pulsed together; GNT_RDY and DONE each asserted 1 cycle after the offer -> grant order is ERR, INT, NET, EU thr 0, 1, 2, 3; final rr_ptr=0.
- Second EUREQ[1] (param 64'h2) while thread 1 is pending (param 64'h1) -> EUOVF[1] pulses 1 cycle; the later grant carries PARAM=64'h1.
- EUREQ[0] pending while INT and NET are re-pulsed after every grant -> after 12 non-EU grants the next grant is EU thr 0; the starve counter returns to 0.
- Hold GNT_RDY=0 for 20 cycles while ERRREQ arrives mid-offer -> the GNT_* fields stay unchanged (no pre-emption); ERR is granted next.
- Assert RESETn=0 during SERVICE -> GNT_VLD, BUSY and PEND are 0 asynchronously; after release the FSM is in IDLE with no offer.
